// File: rtl/vga_grid_decoder_pkg.sv
// Shared constants, colour codes and FSM state for the VGA grid decoder.
// CRC helper exists only when VGA_GRID_DECODER_FRAME_SIG_EN is defined.
package vga_grid_decoder_pkg;

  localparam int CLK_PER_PIX = 2;
  localparam int H_SYNC      = 96;
  localparam int H_BACK      = 48;
  localparam int H_TOTAL     = 800;
  localparam int V_SYNC      = 2;
  localparam int V_BACK      = 33;
  localparam int V_TOTAL     = 525;

  localparam int CELL_W = 80;
  localparam int CELL_H = 60;
  localparam int GRID_N = 8;

  localparam logic [11:0] COL_PAC   = 12'hFF0;
  localparam logic [11:0] COL_GHOST = 12'hF00;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACTIVE,
    COMMIT
  } state_t;

`ifdef VGA_GRID_DECODER_FRAME_SIG_EN
  // CRC-16-CCITT (poly 0x1021) step over one 12-bit pixel, MSB first.
  function automatic logic [15:0] crc16_pix(input logic [15:0] crc_in, input logic [11:0] pix);
    logic [15:0] crc;
    crc = crc_in;
    for (int b = 11; b >= 0; b--) begin
      if (crc[15] ^ pix[b]) crc = {crc[14:0], 1'b0} ^ 16'h1021;
      else                  crc = {crc[14:0], 1'b0};
    end
    return crc;
  endfunction
`endif

endpackage

// File: rtl/vga_grid_decoder_timing.sv
// vga_rx_timing: recovers pixel/line position from hsync/vsync, flags bad
// line/frame lengths and strobes at each grid cell centre.
module vga_rx_timing #(
  parameter int CLK_PER_PIX = 2,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_TOTAL     = 525,
  parameter int CELL_WIDTH  = 80,
  parameter int CELL_HEIGHT = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic       sample_strobe,
  output logic [2:0] cell_i,
  output logic [2:0] cell_j,
  output logic       frame_edge,
  output logic       len_err
);
  import vga_grid_decoder_pkg::*;

  localparam logic [15:0] PH_LAST = 16'(CLK_PER_PIX - 1);
  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);

  logic        hsync_reg, vsync_reg;
  logic        h_seen_reg, v_seen_reg;
  logic [15:0] phase_reg, hcnt_reg, vcnt_reg;
  logic        h_fall, v_fall, pix_tick;
  logic [GRID_N-1:0] col_hit, row_hit;

  assign h_fall     = hsync_reg & ~hsync;
  assign v_fall     = vsync_reg & ~vsync;
  assign pix_tick   = (phase_reg == PH_LAST) && !h_fall;
  assign frame_edge = v_fall;

  // Length checks are skipped until one full line/frame has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_reg  <= 1'b0;
      vsync_reg  <= 1'b0;
      h_seen_reg <= 1'b0;
      v_seen_reg <= 1'b0;
      phase_reg  <= '0;
      hcnt_reg   <= '0;
      vcnt_reg   <= '0;
      len_err    <= 1'b0;
    end else begin
      hsync_reg <= hsync;
      vsync_reg <= vsync;
      len_err   <= 1'b0;
      if (h_fall) begin
        phase_reg  <= '0;
        hcnt_reg   <= '0;
        h_seen_reg <= 1'b1;
        if (h_seen_reg && hcnt_reg != H_LAST) len_err <= 1'b1;
      end else begin
        phase_reg <= (phase_reg == PH_LAST) ? '0 : phase_reg + 16'd1;
        if (pix_tick) hcnt_reg <= hcnt_reg + 16'd1;
      end
      if (v_fall) begin
        vcnt_reg   <= '0;
        v_seen_reg <= 1'b1;
        if (v_seen_reg && vcnt_reg != V_LAST) len_err <= 1'b1;
      end else if (h_fall) begin
        vcnt_reg <= vcnt_reg + 16'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < GRID_N; gi++) begin : g_hit
      assign col_hit[gi] = (hcnt_reg == 16'(H_SYNC + H_BACK + CELL_WIDTH / 2 + CELL_WIDTH * gi));
      assign row_hit[gi] = (vcnt_reg == 16'(V_SYNC + V_BACK + CELL_HEIGHT / 2 + CELL_HEIGHT * gi));
    end
  endgenerate

  always_comb begin
    cell_i = '0;
    cell_j = '0;
    for (int k = 0; k < GRID_N; k++) begin
      if (col_hit[k]) cell_i = 3'(k);
      if (row_hit[k]) cell_j = 3'(k);
    end
  end

  assign sample_strobe = pix_tick && (|col_hit) && (|row_hit);

endmodule

// File: rtl/vga_grid_decoder.sv
// Decodes PacMan/ghost grid cells from a received VGA stream.
// Define VGA_GRID_DECODER_FRAME_SIG_EN to add the frame_sig CRC output.
module vga_grid_decoder #(
  parameter int CLK_PER_PIX = vga_grid_decoder_pkg::CLK_PER_PIX,
  parameter int H_SYNC      = vga_grid_decoder_pkg::H_SYNC,
  parameter int H_BACK      = vga_grid_decoder_pkg::H_BACK,
  parameter int H_TOTAL     = vga_grid_decoder_pkg::H_TOTAL,
  parameter int V_SYNC      = vga_grid_decoder_pkg::V_SYNC,
  parameter int V_BACK      = vga_grid_decoder_pkg::V_BACK,
  parameter int V_TOTAL     = vga_grid_decoder_pkg::V_TOTAL,
  parameter int CELL_WIDTH  = vga_grid_decoder_pkg::CELL_W,
  parameter int CELL_HEIGHT = vga_grid_decoder_pkg::CELL_H
) (
`ifdef VGA_GRID_DECODER_FRAME_SIG_EN
  output logic [15:0] frame_sig,
`endif
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [3:0] vga_r,
  input  logic [3:0] vga_g,
  input  logic [3:0] vga_b,
  output logic [2:0] pac_x,
  output logic [2:0] pac_y,
  output logic [2:0] ghost_x,
  output logic [2:0] ghost_y,
  output logic       pac_found,
  output logic       ghost_found,
  output logic       dup_err,
  output logic       sync_err,
  output logic       frame_done
);
  import vga_grid_decoder_pkg::*;

  logic        sample_strobe, frame_edge, len_err;
  logic [2:0]  cell_i, cell_j;
  logic [11:0] pix;
  state_t      state_reg;

  logic [2:0]  sh_pac_x_reg, sh_pac_y_reg, sh_ghost_x_reg, sh_ghost_y_reg;
  logic        sh_pac_found_reg, sh_ghost_found_reg, sh_dup_reg;
`ifdef VGA_GRID_DECODER_FRAME_SIG_EN
  logic [15:0] sh_crc_reg;
`endif

  assign pix = {vga_r, vga_g, vga_b};

  vga_rx_timing #(
    .CLK_PER_PIX(CLK_PER_PIX), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOTAL(V_TOTAL),
    .CELL_WIDTH(CELL_WIDTH), .CELL_HEIGHT(CELL_HEIGHT)
  ) u_timing (
    .clk(clk), .rst(reset), .hsync(hsync), .vsync(vsync),
    .sample_strobe(sample_strobe), .cell_i(cell_i), .cell_j(cell_j),
    .frame_edge(frame_edge), .len_err(len_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= WAIT_FRAME;
      pac_x              <= '0;
      pac_y              <= '0;
      ghost_x            <= '0;
      ghost_y            <= '0;
      pac_found          <= 1'b0;
      ghost_found        <= 1'b0;
      dup_err            <= 1'b0;
      sync_err           <= 1'b0;
      frame_done         <= 1'b0;
      sh_pac_x_reg       <= '0;
      sh_pac_y_reg       <= '0;
      sh_ghost_x_reg     <= '0;
      sh_ghost_y_reg     <= '0;
      sh_pac_found_reg   <= 1'b0;
      sh_ghost_found_reg <= 1'b0;
      sh_dup_reg         <= 1'b0;
`ifdef VGA_GRID_DECODER_FRAME_SIG_EN
      frame_sig          <= '0;
      sh_crc_reg         <= 16'hFFFF;
`endif
    end else begin
      frame_done <= 1'b0;
      if (len_err) sync_err <= 1'b1;
      case (state_reg)
        WAIT_FRAME: if (frame_edge) state_reg <= ACTIVE;
        ACTIVE: begin
          if (frame_edge) begin
            state_reg <= COMMIT;
          end else if (sample_strobe) begin
            if (pix == COL_PAC) begin
              if (sh_pac_found_reg) sh_dup_reg <= 1'b1;
              else begin
                sh_pac_found_reg <= 1'b1;
                sh_pac_x_reg     <= cell_i;
                sh_pac_y_reg     <= cell_j;
              end
            end
            if (pix == COL_GHOST) begin
              if (sh_ghost_found_reg) sh_dup_reg <= 1'b1;
              else begin
                sh_ghost_found_reg <= 1'b1;
                sh_ghost_x_reg     <= cell_i;
                sh_ghost_y_reg     <= cell_j;
              end
            end
`ifdef VGA_GRID_DECODER_FRAME_SIG_EN
            sh_crc_reg <= crc16_pix(sh_crc_reg, pix);
`endif
          end
        end
        COMMIT: begin
          // The first cell row is far below line 0, so clearing here loses no samples.
          pac_x              <= sh_pac_x_reg;
          pac_y              <= sh_pac_y_reg;
          ghost_x            <= sh_ghost_x_reg;
          ghost_y            <= sh_ghost_y_reg;
          pac_found          <= sh_pac_found_reg;
          ghost_found        <= sh_ghost_found_reg;
          dup_err            <= sh_dup_reg;
          frame_done         <= 1'b1;
          sh_pac_x_reg       <= '0;
          sh_pac_y_reg       <= '0;
          sh_ghost_x_reg     <= '0;
          sh_ghost_y_reg     <= '0;
          sh_pac_found_reg   <= 1'b0;
          sh_ghost_found_reg <= 1'b0;
          sh_dup_reg         <= 1'b0;
`ifdef VGA_GRID_DECODER_FRAME_SIG_EN
          frame_sig          <= sh_crc_reg;
          sh_crc_reg         <= 16'hFFFF;
`endif
          state_reg          <= ACTIVE;
        end
        default: state_reg <= WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_grid_decoder.sv
// Directed bench for vga_grid_decoder on a shrunken timing/grid so full frames stay short.
// Each table row describes one frame to send and the outputs expected from the previous frame's commit.
module tb_vga_grid_decoder;

  localparam int CPP = 2;
  localparam int HS = 4, HB = 4, HT = 72;
  localparam int VS = 2, VB = 2, VT = 38;
  localparam int CW = 8, CH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync = 1'b1, vsync = 1'b1;
  logic [3:0] vga_r = '0, vga_g = '0, vga_b = '0;
  logic [2:0] pac_x, pac_y, ghost_x, ghost_y;
  logic       pac_found, ghost_found, dup_err, sync_err, frame_done;
`ifdef VGA_GRID_DECODER_FRAME_SIG_EN
  logic [15:0] frame_sig;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_grid_decoder #(
    .CLK_PER_PIX(CPP), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .CELL_WIDTH(CW), .CELL_HEIGHT(CH)
  ) dut (
`ifdef VGA_GRID_DECODER_FRAME_SIG_EN
    .frame_sig(frame_sig),
`endif
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .pac_found(pac_found), .ghost_found(ghost_found), .dup_err(dup_err),
    .sync_err(sync_err), .frame_done(frame_done)
  );

  typedef struct {
    int p0_v, p0_i, p0_j;
    int p1_v, p1_i, p1_j;
    int g_v, g_i, g_j;
    logic [11:0] bg;
    int short_line;
    int e_done, e_pf, e_px, e_py, e_gf, e_gx, e_gy, e_dup, e_sync;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [11:0] cell_col(input vec_t v, input int i, input int j);
    if (v.p0_v != 0 && v.p0_i == i && v.p0_j == j) return 12'hFF0;
    if (v.p1_v != 0 && v.p1_i == i && v.p1_j == j) return 12'hFF0;
    if (v.g_v != 0 && v.g_i == i && v.g_j == j) return 12'hF00;
    return v.bg;
  endfunction

`ifdef VGA_GRID_DECODER_FRAME_SIG_EN
  function automatic logic [15:0] crc_model(input vec_t v);
    logic [15:0] crc;
    logic [11:0] w;
    logic fb;
    crc = 16'hFFFF;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++) begin
        w = cell_col(v, i, j);
        for (int b = 11; b >= 0; b--) begin
          fb  = crc[15] ^ w[b];
          crc = {crc[14:0], 1'b0};
          if (fb) crc = crc ^ 16'h1021;
        end
      end
    return crc;
  endfunction
`endif

  task automatic chk(input string name, input int k, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s (frame %0d): got %0h, want %0h", name, k, got, exp);
    end
  endtask

  task automatic check_outputs(input int k);
    chk("frame_done", k, int'(frame_done), vecs[k].e_done);
    chk("pac_found", k, int'(pac_found), vecs[k].e_pf);
    chk("pac_x", k, int'(pac_x), vecs[k].e_px);
    chk("pac_y", k, int'(pac_y), vecs[k].e_py);
    chk("ghost_found", k, int'(ghost_found), vecs[k].e_gf);
    chk("ghost_x", k, int'(ghost_x), vecs[k].e_gx);
    chk("ghost_y", k, int'(ghost_y), vecs[k].e_gy);
    chk("dup_err", k, int'(dup_err), vecs[k].e_dup);
    chk("sync_err", k, int'(sync_err), vecs[k].e_sync);
`ifdef VGA_GRID_DECODER_FRAME_SIG_EN
    if (vecs[k].e_done != 0) chk("frame_sig", k, int'(frame_sig), int'(crc_model(vecs[k-1])));
    else                     chk("frame_sig", k, int'(frame_sig), 0);
`endif
    $display("[TB] frame %0d: done=%0d pac=%0d(%0d,%0d) ghost=%0d(%0d,%0d) dup=%0d sync=%0d",
             k, frame_done, pac_found, pac_x, pac_y, ghost_found, ghost_x, ghost_y, dup_err, sync_err);
  endtask

  // Drives lines [first,last] of frame k; inputs change on the falling clock edge.
  task automatic drive_lines(input int k, input int first, input int last);
    for (int ln = first; ln <= last; ln++) begin
      int npx;
      npx = (ln == vecs[k].short_line) ? HT - 1 : HT;
      for (int px = 0; px < npx; px++) begin
        for (int c = 0; c < CPP; c++) begin
          logic [11:0] col;
          @(negedge clk);
          if (ln == 0 && px == 0 && c == 1) chk("frame_done_t1", k, int'(frame_done), 0);
          if (ln == 1 && px == 0 && c == 0) chk("frame_done_t3", k, int'(frame_done), 0);
          if (ln == 0 && px == 1 && c == 0) check_outputs(k);
          if (ln == 0 && px == 1 && c == 1) chk("frame_done_t3", k, int'(frame_done), 0);
          col = 12'h000;
          if (px >= HS + HB && ln >= VS + VB && ln < VS + VB + 8 * CH)
            col = cell_col(vecs[k], (px - HS - HB) / CW, (ln - VS - VB) / CH);
          hsync = (px < HS) ? 1'b0 : 1'b1;
          vsync = (ln < VS) ? 1'b0 : 1'b1;
          {vga_r, vga_g, vga_b} = col;
        end
      end
    end
  endtask

  initial begin
    //           pac0      pac1      ghost     bg       short  done pf px py gf gx gy dup sync
    vecs[0] = '{1, 3, 5, 0, 0, 0, 1, 7, 0, 12'h00F, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 12'hFE0, -1, 1, 1, 3, 5, 1, 7, 0, 0, 0};
    vecs[2] = '{1, 1, 1, 1, 6, 2, 0, 0, 0, 12'h0F0, -1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, -1, 1, 1, 1, 1, 0, 0, 0, 1, 0};
    vecs[4] = '{1, 4, 4, 0, 0, 0, 1, 0, 3, 12'h000,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{1, 0, 7, 0, 0, 0, 1, 7, 7, 12'hF01, -1, 1, 1, 4, 4, 1, 0, 3, 0, 1};
    vecs[6] = '{1, 5, 5, 0, 0, 0, 1, 5, 6, 12'h000, -1, 1, 1, 0, 7, 1, 7, 7, 0, 1};
    vecs[7] = '{1, 6, 1, 0, 0, 0, 1, 2, 3, 12'h000, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, -1, 1, 1, 6, 1, 1, 2, 3, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_frame_done", -1, int'(frame_done), 0);
    chk("rst_sync_err", -1, int'(sync_err), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      if (k == 6) begin
        drive_lines(k, 0, 19);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_pac_found", k, int'(pac_found), 0);
        chk("midrst_pac_y", k, int'(pac_y), 0);
        chk("midrst_ghost_found", k, int'(ghost_found), 0);
        chk("midrst_ghost_x", k, int'(ghost_x), 0);
        chk("midrst_sync_err", k, int'(sync_err), 0);
        $display("[TB] mid-frame reset: pac=%0d ghost=%0d sync=%0d", pac_found, ghost_found, sync_err);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        drive_lines(k, 20, VT - 1);
      end else if (k == 8) begin
        drive_lines(k, 0, 1);
      end else begin
        drive_lines(k, 0, VT - 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
